// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: counter encodings and helpers shared with the fetch-side predictor
package branch_resolve_unit_pkg;
  localparam int CNT_W = 2;
  localparam int REDIRECT_INC = 4;
  typedef enum logic [CNT_W-1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;
  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] c, input logic taken);
    return taken ? (c == CNT_ST ? CNT_ST : c + 1'b1) : (c == CNT_SNT ? CNT_SNT : c - 1'b1);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// bru_update_fifo: circular FIFO of pending PHT updates, all entries visible for youngest-match search
module bru_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valids,
  output logic [PTR_W-1:0]          wr_ptr
);
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0] count;
  logic do_push, do_pop;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = empty ? '0 : entries[rd_ptr];
  always_comb begin
    valids = '0;
    for (int i = 0; i < DEPTH; i++)
      valids[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) entries[wr_ptr] <= push_data;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks EX branch outcomes against predictions, flushes on mispredict, queues PHT updates
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int IDX_W = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [1:0]        ex_pred_cnt,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              pht_wr_valid,
  input  logic              pht_wr_ready,
  output logic [IDX_W-1:0]  pht_wr_idx,
  output logic [1:0]        pht_wr_data,
  output logic [15:0]       branch_cnt,
  output logic [15:0]       mispredict_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int E_W = IDX_W + CNT_W;
  logic accept, mispredict, full, empty, found;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] base, next_cnt;
  logic [E_W-1:0] head;
  logic [FIFO_DEPTH-1:0][E_W-1:0] entries;
  logic [FIFO_DEPTH-1:0] valids;
  logic [PTR_W-1:0] wr_ptr, slot;
  assign ex_ready = !full && !rst;
  assign accept = ex_valid && ex_ready;
  assign mispredict = ex_pred_taken != ex_taken;
  assign idx = ex_pc[IDX_W+1:2];
  assign next_cnt = sat_next(base, ex_taken);
  assign pht_wr_valid = !empty;
  assign {pht_wr_idx, pht_wr_data} = head;
  // Walk back from the newest slot so the first hit is the youngest pending update
  always_comb begin
    base = ex_pred_cnt;
    found = 1'b0;
    slot = '0;
    for (int k = 1; k <= FIFO_DEPTH; k++) begin
      slot = wr_ptr - PTR_W'(k);
      if (!found && valids[slot] && entries[slot][E_W-1:CNT_W] == idx) begin
        base = entries[slot][CNT_W-1:0];
        found = 1'b1;
      end
    end
  end
  bru_update_fifo #(.DEPTH(FIFO_DEPTH), .W(E_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .push_data({idx, next_cnt}),
    .pop(pht_wr_ready),
    .head(head),
    .full(full),
    .empty(empty),
    .entries(entries),
    .valids(valids),
    .wr_ptr(wr_ptr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      flush <= 1'b0;
      redirect_pc <= '0;
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      flush <= accept && mispredict;
      if (accept && mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + PC_W'(REDIRECT_INC);
      if (accept && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      if (accept && mispredict && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
endmodule
